serial_pattern_gen: RTL and testbench

//  Serial bit-stream transmitter that drives pattern-detector FSMs (011/1010 detectors, etc.).

---
 rtl/serial_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_serial_pattern_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: loads a pattern over valid/ready, shifts it out MSB-first with
// repeats and gaps. Define SERIAL_PATTERN_GEN_PRBS_GAP_EN to fill gaps with PRBS7 bits.
module serial_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [CNT_W-1:0]   load_repeat,
  input  logic [GAP_W-1:0]   load_gap,
  input  logic               enable,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               pat_start,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, pat_sh;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d, len_in, last_idx;
  logic [CNT_W-1:0]   rep_q, rep_d, rcnt_q, rcnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d, gcnt_q, gcnt_d;
  logic               done_q, done_d;

  assign len_in   = (load_len > MAX_L) ? MAX_L : load_len;
  assign last_idx = len_q - LEN_W'(1);
  // shift instead of a variable bit-select so idx width need not match the pattern's index width
  assign pat_sh   = pat_q >> idx_q;

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

`ifdef SERIAL_PATTERN_GEN_PRBS_GAP_EN
  logic [6:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          lfsr_q <= 7'h7F;
    else if (state_q == GAP && enable) lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      rcnt_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      rcnt_q  <= rcnt_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    rcnt_d    = rcnt_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    done_d    = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    pat_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          pat_d  = load_pattern;
          len_d  = len_in;
          rep_d  = load_repeat;
          gap_d  = load_gap;
          rcnt_d = '0;
          gcnt_d = '0;
          idx_d  = len_in - LEN_W'(1);
          // a zero-length load completes immediately without leaving IDLE
          if (len_in != '0) state_d = SEND;
          else              done_d  = 1'b1;
        end
      end
      SEND: begin
        ser_valid = enable;
        ser_out   = enable & pat_sh[0];
        pat_start = enable && (idx_q == last_idx);
        if (enable) begin
          if (idx_q == '0) begin
            if (rcnt_q == rep_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              rcnt_d  = rcnt_q + CNT_W'(1);
              idx_d   = last_idx;
              gcnt_d  = '0;
              state_d = (gap_q != '0) ? GAP : SEND;
            end
          end else begin
            idx_d = idx_q - LEN_W'(1);
          end
        end
      end
      GAP: begin
`ifdef SERIAL_PATTERN_GEN_PRBS_GAP_EN
        ser_valid = enable;
        ser_out   = enable & lfsr_q[6];
`endif
        if (enable) begin
          if (gcnt_q == gap_q - GAP_W'(1)) begin
            state_d = SEND;
            idx_d   = last_idx;
          end else begin
            gcnt_d = gcnt_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: queue-based stream model checked every cycle, plus literal
// expectations per directed case.
module tb_serial_pattern_gen;
  logic       clk = 1'b0, rst = 1'b1, load_valid = 1'b0, enable = 1'b1;
  logic [7:0] load_pattern = '0;
  logic [3:0] load_len = '0, load_repeat = '0, load_gap = '0;
  logic       load_ready, ser_out, ser_valid, pat_start, busy, done;

  serial_pattern_gen #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_pattern(load_pattern), .load_len(load_len), .load_repeat(load_repeat),
    .load_gap(load_gap), .enable(enable), .ser_out(ser_out), .ser_valid(ser_valid),
    .pat_start(pat_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic rec_v [0:1023];
  logic rec_o [0:1023];
  logic rec_s [0:1023];
  logic rec_d [0:1023];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rec_v[cyc] <= ser_valid;
    rec_o[cyc] <= ser_out;
    rec_s[cyc] <= pat_start;
    rec_d[cyc] <= done;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
    end
  endtask

  // Model: the whole transfer as a queue of per-enabled-cycle entries
  typedef struct packed { logic kind; logic b; logic st; } ent_t;  // kind=1: gap slot
  ent_t       q[$];
  logic       m_done = 1'b0;
  logic [6:0] m_lfsr = 7'h7F;

  task automatic build(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                       input logic [3:0] g);
    int   n;
    ent_t e;
    n = (l > 8) ? 8 : int'(l);
    if (n == 0) return;
    for (int rr = 0; rr <= int'(r); rr++) begin
      for (int i = n - 1; i >= 0; i--) begin
        e.kind = 1'b0; e.b = p[i]; e.st = (i == n - 1);
        q.push_back(e);
      end
      if (rr < int'(r))
        for (int k = 0; k < int'(g); k++) begin
          e = '0; e.kind = 1'b1;
          q.push_back(e);
        end
    end
  endtask

  initial forever begin
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_done = 1'b0;
      m_lfsr = 7'h7F;
    end else begin
      m_done = 1'b0;
      if (q.size() != 0) begin
        if (enable) begin
          e = q.pop_front();
          if (e.kind) m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
          if (q.size() == 0) m_done = 1'b1;
        end
      end else if (load_valid) begin
        build(load_pattern, load_len, load_repeat, load_gap);
        if (q.size() == 0) m_done = 1'b1;
      end
    end
  end

  initial forever begin
    logic eb, ev, eo, es;
    ent_t e;
    @(negedge clk);
    if (rst) begin
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", load_ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_valid", ser_valid, 1'b0);
      chk("rst_out", ser_out, 1'b0);
      chk("rst_start", pat_start, 1'b0);
    end else begin
      eb = (q.size() != 0);
      ev = 1'b0; eo = 1'b0; es = 1'b0;
      if (eb && enable) begin
        e = q[0];
        if (e.kind) begin
`ifdef SERIAL_PATTERN_GEN_PRBS_GAP_EN
          ev = 1'b1; eo = m_lfsr[6];
`endif
        end else begin
          ev = 1'b1; eo = e.b; es = e.st;
        end
      end
      chk("m_busy", busy, eb);
      chk("m_ready", load_ready, !eb);
      chk("m_done", done, m_done);
      chk("m_valid", ser_valid, ev);
      chk("m_out", ser_out, eo);
      chk("m_start", pat_start, es);
    end
  end

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                         input logic [3:0] g, output int ks);
    @(posedge clk); #1;
    load_valid = 1'b1; load_pattern = p; load_len = l; load_repeat = r; load_gap = g;
    @(posedge clk); #1;
    load_valid = 1'b0;
    ks = cyc;  // index of the first cycle after the accepting edge
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done timeout actual=0 required=1", nm);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int ks, nd;
    logic [7:0] lit;
    #1;
    chk("init_ready", load_ready, 1'b1);
    chk("init_busy", busy, 1'b0);
    chk("init_valid", ser_valid, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // case 1
    do_load(8'h03, 4'd3, 4'd0, 4'd0, ks);
    wait_done("c1");
    chk("c1_v0", rec_v[ks], 1'b1);
    chk("c1_b0", rec_o[ks], 1'b0);
    chk("c1_b1", rec_o[ks+1], 1'b1);
    chk("c1_b2", rec_o[ks+2], 1'b1);
    chk("c1_start", rec_s[ks], 1'b1);
    chk("c1_noearly", rec_d[ks+2], 1'b0);
    chk("c1_done", rec_d[ks+3], 1'b1);

    // case 2
    do_load(8'h0A, 4'd4, 4'd2, 4'd0, ks);
    wait_done("c2");
    for (int i = 0; i < 12; i++) begin
      chk("c2_valid", rec_v[ks+i], 1'b1);
      chk("c2_bit", rec_o[ks+i], (i % 2) == 0);
      chk("c2_start", rec_s[ks+i], (i % 4) == 0);
    end
    nd = 0;
    for (int i = 0; i <= 12; i++) nd += int'(rec_d[ks+i]);
    chk("c2_one_done", nd == 1, 1'b1);
    chk("c2_done", rec_d[ks+12], 1'b1);

    // case 3 (first gaps since reset, so PRBS filler starts from 7'h7F)
    do_load(8'h03, 4'd3, 4'd1, 4'd2, ks);
    wait_done("c3");
    chk("c3_b0", rec_o[ks], 1'b0);
    chk("c3_b2", rec_o[ks+2], 1'b1);
`ifdef SERIAL_PATTERN_GEN_PRBS_GAP_EN
    chk("c3_gv0", rec_v[ks+3], 1'b1);
    chk("c3_go0", rec_o[ks+3], 1'b1);
    chk("c3_gv1", rec_v[ks+4], 1'b1);
    chk("c3_go1", rec_o[ks+4], 1'b1);
`else
    chk("c3_gv0", rec_v[ks+3], 1'b0);
    chk("c3_gv1", rec_v[ks+4], 1'b0);
`endif
    chk("c3_gstart", rec_s[ks+3], 1'b0);
    chk("c3_start2", rec_s[ks+5], 1'b1);
    chk("c3_b3", rec_o[ks+5], 1'b0);
    chk("c3_b5", rec_o[ks+7], 1'b1);
    chk("c3_done", rec_d[ks+8], 1'b1);

    // case 4: stall three cycles after bit 1
    do_load(8'h0A, 4'd4, 4'd2, 4'd0, ks);
    @(posedge clk); #1;
    @(posedge clk); #1; enable = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    enable = 1'b1;
    wait_done("c4");
    chk("c4_b1", rec_o[ks+1], 1'b0);
    chk("c4_stall0", rec_v[ks+2], 1'b0);
    chk("c4_stall2", rec_v[ks+4], 1'b0);
    chk("c4_b2", rec_o[ks+5], 1'b1);
    chk("c4_start4", rec_s[ks+7], 1'b1);
    chk("c4_noearly", rec_d[ks+12], 1'b0);
    chk("c4_done", rec_d[ks+15], 1'b1);

    // case 5: reset during bit 5
    do_load(8'h0A, 4'd4, 4'd2, 4'd0, ks);
    repeat (5) begin @(posedge clk); #1; end
    #2; rst = 1'b1; #1;
    chk("c5_busy", busy, 1'b0);
    chk("c5_valid", ser_valid, 1'b0);
    chk("c5_ready", load_ready, 1'b1);
    @(posedge clk); #1; rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    nd = 0;
    for (int i = 5; i < 25; i++) nd += int'(rec_d[ks+i]);
    chk("c5_nodone", nd == 0, 1'b1);
    do_load(8'h03, 4'd3, 4'd0, 4'd0, ks);
    wait_done("c5_reload");
    chk("c5_rb1", rec_o[ks+1], 1'b1);
    chk("c5_rdone", rec_d[ks+3], 1'b1);

    // case 6: zero length, then clamped length
    do_load(8'hFF, 4'd0, 4'd3, 4'd2, ks);
    repeat (3) @(posedge clk);
    #1;
    chk("c6_done0", rec_d[ks], 1'b1);
    chk("c6_v0", rec_v[ks], 1'b0);
    chk("c6_v1", rec_v[ks+1], 1'b0);
    chk("c6_done1", rec_d[ks+1], 1'b0);
    lit = 8'hA5;
    do_load(lit, 4'd12, 4'd0, 4'd0, ks);
    wait_done("c6_clamp");
    for (int i = 0; i < 8; i++) chk("c6_bit", rec_o[ks+i], lit[7-i]);
    chk("c6_after", rec_v[ks+8], 1'b0);
    chk("c6_cdone", rec_d[ks+8], 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
